// File: rtl/solver_scheduler_pkg.sv
// Shared definitions for the solver scheduler and the pattern solvers.
// Holds FSM state encodings, pixel width, default frame geometry and a
// small index-wrap helper used by the round-robin arbiter.
package solver_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned PIX_W           = 4;
  localparam int unsigned DEF_NUM_SOLVERS = 4;
  localparam int unsigned DEF_NUM_COLUMNS = 640;
  localparam int unsigned DEF_NUM_ROWS    = 480;
  localparam int unsigned DEF_ADDR_W      = 19;

  // Folds idx back into [0, n) assuming idx < 2n.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/solver_scheduler_rr_arbiter.sv
// Round-robin arbiter for the solver holding buffers.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   clear          : forces the priority pointer to 0
//   req[N]         : valid holding buffers
//   hold           : current grant presented but not accepted
//   advance        : current grant accepted (transfer this cycle)
//   grant[N]       : one-hot grant
//   grant_idx      : index of the granted requester
//   grant_valid    : some requester is granted
// Only the priority pointer is registered; the grant is combinational.
module rr_arbiter
  import solver_scheduler_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [N-1:0]     req,
  input  logic             hold,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] scan_idx;

  // First requester at or after ptr_q wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = IDX_W'(rr_wrap(32'(ptr_q) + k, N));
      if (!grant_valid && req[scan_idx]) begin
        grant_valid     = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // A stalled grant parks the pointer on itself, so the scan keeps
  // returning the same buffer even if a higher-priority one fills up.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (advance) begin
      ptr_d = IDX_W'(rr_wrap(32'(grant_idx) + 32'd1, N));
    end else if (hold) begin
      ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/solver_scheduler.sv
// Frame sequencer and result arbiter for a bank of interleaved pattern
// solvers. Pulses the shared solver reset to start a frame, captures each
// solver's pixel into a one-entry holding buffer (stalling the solver via
// solver_continue while occupied) and merges the buffers round-robin onto
// one frame-buffer write port with a linear pixel address.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-low reset
//   start               : begin a frame (IDLE only)
//   solver_reset        : one-cycle restart pulse to all solvers
//   solver_continue[N]  : per-solver stall
//   solver_ready[N]     : per-solver result strobe
//   solver_out[4N]      : packed results, solver i at [4i+3:4i]
//   solver_done[N]      : per-solver frame-complete flags
//   wr_en/addr/data     : frame-buffer write request
//   wr_ready            : frame-buffer accept
//   busy                : high in LOAD and RUN
//   frame_done          : one-cycle end-of-frame pulse
//   overflow            : sticky dropped-result flag
module solver_scheduler
  import solver_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS = DEF_NUM_SOLVERS,
  parameter int unsigned NUM_COLUMNS = DEF_NUM_COLUMNS,
  parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         solver_reset,
  output logic [NUM_SOLVERS-1:0]       solver_continue,
  input  logic [NUM_SOLVERS-1:0]       solver_ready,
  input  logic [PIX_W*NUM_SOLVERS-1:0] solver_out,
  input  logic [NUM_SOLVERS-1:0]       solver_done,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [PIX_W-1:0]             wr_data,
  input  logic                         wr_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int unsigned IDX_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int unsigned COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;
  localparam logic [AW1-1:0]   ROW_STEP     = AW1'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);
  localparam logic [AW1-1:0]   FRAME_PIXELS = AW1'(NUM_COLUMNS * NUM_ROWS);
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(NUM_COLUMNS - 1);

  state_e state_q, state_d;

  logic [NUM_SOLVERS-1:0] valid_q, valid_d;
  logic [PIX_W-1:0]       data_q  [NUM_SOLVERS];
  logic [PIX_W-1:0]       data_d  [NUM_SOLVERS];
  logic [ADDR_W-1:0]      baddr_q [NUM_SOLVERS];
  logic [ADDR_W-1:0]      baddr_d [NUM_SOLVERS];
  logic [ADDR_W-1:0]      addr_q  [NUM_SOLVERS];
  logic [ADDR_W-1:0]      addr_d  [NUM_SOLVERS];
  logic [COL_W-1:0]       col_q   [NUM_SOLVERS];
  logic [COL_W-1:0]       col_d   [NUM_SOLVERS];
  logic                   overflow_q, overflow_d;

  logic [NUM_SOLVERS-1:0] grant;
  logic [NUM_SOLVERS-1:0] drain;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   frame_end;
  logic [AW1-1:0]         step_addr;

  rr_arbiter #(
    .N (NUM_SOLVERS)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .clear       (state_q == ST_LOAD),
    .req         (valid_q),
    .hold        (grant_valid && !wr_ready),
    .advance     (grant_valid && wr_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign wr_en           = grant_valid;
  assign wr_addr         = grant_valid ? baddr_q[grant_idx] : '0;
  assign wr_data         = grant_valid ? data_q[grant_idx] : '0;
  assign drain           = grant & {NUM_SOLVERS{wr_ready}};
  assign solver_continue = valid_q & ~drain;
  assign overflow        = overflow_q;
  assign frame_end       = (&solver_done) && !(|valid_q) && !wr_en;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (frame_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    solver_reset = (state_q == ST_LOAD);
    busy         = (state_q == ST_LOAD) || (state_q == ST_RUN);
    frame_done   = (state_q == ST_RUN) && frame_end;
  end

  // Buffers and address counters
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    baddr_d    = baddr_q;
    addr_d     = addr_q;
    col_d      = col_q;
    overflow_d = overflow_q;
    step_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) overflow_d = 1'b0;
      end
      ST_LOAD: begin
        overflow_d = 1'b0;
        valid_d    = '0;
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
          addr_d[i] = ADDR_W'(i * NUM_COLUMNS);
          col_d[i]  = '0;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
          if (drain[i]) valid_d[i] = 1'b0;
          if (solver_ready[i]) begin
            if (valid_q[i] && !drain[i]) begin
              overflow_d = 1'b1;
            end else begin
              valid_d[i] = 1'b1;
              data_d[i]  = solver_out[PIX_W*i +: PIX_W];
              baddr_d[i] = addr_q[i];
              if (col_q[i] == LAST_COL) begin
                col_d[i]  = '0;
                step_addr = {1'b0, addr_q[i]} + ROW_STEP;
              end else begin
                col_d[i]  = col_q[i] + COL_W'(1);
                step_addr = {1'b0, addr_q[i]} + AW1'(1);
              end
              // Saturate past the last frame row so a runaway solver
              // can never wrap back onto the top of the frame.
              if (step_addr < FRAME_PIXELS) addr_d[i] = step_addr[ADDR_W-1:0];
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        data_q[i]  <= '0;
        baddr_q[i] <= '0;
        addr_q[i]  <= '0;
        col_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      baddr_q    <= baddr_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: tb/tb_solver_scheduler.sv
module tb_solver_scheduler;

  localparam int NS = 4;
  localparam int NC = 8;
  localparam int NR = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          solver_reset;
  logic [NS-1:0] solver_continue;
  logic [NS-1:0] solver_ready;
  logic [4*NS-1:0] solver_out;
  logic [NS-1:0] solver_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_ready;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  solver_scheduler #(
    .NUM_SOLVERS (NS),
    .NUM_COLUMNS (NC),
    .NUM_ROWS    (NR),
    .ADDR_W      (AW)
  ) dut (
    .clock           (clk),
    .reset           (rst_n),
    .start           (start),
    .solver_reset    (solver_reset),
    .solver_continue (solver_continue),
    .solver_ready    (solver_ready),
    .solver_out      (solver_out),
    .solver_done     (solver_done),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .busy            (busy),
    .frame_done      (frame_done),
    .overflow        (overflow)
  );

  typedef struct {
    logic [3:0]  rdy;
    logic [15:0] dout;
    logic [3:0]  done;
    logic        wrr;
    logic        en;
    logic [5:0]  addr;
    logic [3:0]  data;
    logic [3:0]  cont;
    logic        ovf;
    logic        fd;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pix(input int r, input int c);
    return 4'((r * 5 + c * 3) & 15);
  endfunction

  task automatic step_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int wrap_addr [8] = '{17, 18, 19, 20, 21, 22, 23, 48};
  int cnt [NS];
  int lat [NS];
  bit seen [NR*NC];
  int writes, fdone_cnt, nseen, a;
  bit fin;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // contention: all four load at once, then drain 0,1,2,3
    tbl[0]  = '{4'b1111, 16'hDCBA, 4'b0, 1'b1, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd0,  4'hA, 4'b1110, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd8,  4'hB, 4'b1100, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd16, 4'hC, 4'b1000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd24, 4'hD, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b0, 1'b0};
    // backpressure on buffer 1; buffer 0 fills during the stall
    tbl[6]  = '{4'b0010, 16'h0050, 4'b0, 1'b1, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b0, 1'b0};
    tbl[7]  = '{4'b0001, 16'h0007, 4'b0, 1'b0, 1'b1, 6'd9,  4'h5, 4'b0010, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 16'h0000, 4'b0, 1'b0, 1'b1, 6'd9,  4'h5, 4'b0011, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 16'h0000, 4'b0, 1'b0, 1'b1, 6'd9,  4'h5, 4'b0011, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 16'h0000, 4'b0, 1'b0, 1'b1, 6'd9,  4'h5, 4'b0011, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 16'h0000, 4'b0, 1'b0, 1'b1, 6'd9,  4'h5, 4'b0011, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd9,  4'h5, 4'b0001, 1'b0, 1'b0};
    tbl[13] = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd1,  4'h7, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b0, 1'b0};
    // protocol violation on buffer 0
    tbl[15] = '{4'b0001, 16'h0003, 4'b0, 1'b0, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b0, 1'b0};
    tbl[16] = '{4'b0001, 16'h0009, 4'b0, 1'b0, 1'b1, 6'd2,  4'h3, 4'b0001, 1'b0, 1'b0};
    tbl[17] = '{4'b0000, 16'h0000, 4'b0, 1'b0, 1'b1, 6'd2,  4'h3, 4'b0001, 1'b1, 1'b0};
    tbl[18] = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b1, 6'd2,  4'h3, 4'b0000, 1'b1, 1'b0};
    tbl[19] = '{4'b0000, 16'h0000, 4'b0, 1'b1, 1'b0, 6'd0,  4'h0, 4'b0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; solver_ready = '0; solver_out = '0;
    solver_done = '0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_solver_reset", 32'(solver_reset), 0);
    chk("rst_continue", 32'(solver_continue), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    step_start();
    #1;
    chk("load_solver_reset", 32'(solver_reset), 1);
    chk("load_busy", 32'(busy), 1);
    @(negedge clk); #1;
    chk("run_solver_reset", 32'(solver_reset), 0);
    chk("run_busy", 32'(busy), 1);

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      solver_ready = tbl[v].rdy;
      solver_out   = tbl[v].dout;
      solver_done  = tbl[v].done;
      wr_ready     = tbl[v].wrr;
      #1;
      chk($sformatf("vec%0d_wr_en", v), 32'(wr_en), 32'(tbl[v].en));
      chk($sformatf("vec%0d_wr_addr", v), 32'(wr_addr), 32'(tbl[v].addr));
      chk($sformatf("vec%0d_wr_data", v), 32'(wr_data), 32'(tbl[v].data));
      chk($sformatf("vec%0d_continue", v), 32'(solver_continue), 32'(tbl[v].cont));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(tbl[v].ovf));
      chk($sformatf("vec%0d_frame_done", v), 32'(frame_done), 32'(tbl[v].fd));
    end

    // row wrap on solver 2 at full throughput, last drain with all done
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      solver_ready = (k < 8) ? 4'b0100 : 4'b0000;
      solver_out   = {4'h0, 4'(k), 8'h00};
      solver_done  = (k == 8) ? 4'b1111 : 4'b0000;
      wr_ready     = 1'b1;
      #1;
      if (k == 0) begin
        chk("wrap_first_en", 32'(wr_en), 0);
      end else begin
        chk($sformatf("wrap%0d_en", k), 32'(wr_en), 1);
        chk($sformatf("wrap%0d_addr", k), 32'(wr_addr), 32'(wrap_addr[k-1]));
        chk($sformatf("wrap%0d_data", k), 32'(wr_data), 32'(k - 1));
        chk($sformatf("wrap%0d_continue", k), 32'(solver_continue), 0);
        chk($sformatf("wrap%0d_frame_done", k), 32'(frame_done), 0);
      end
    end
    @(negedge clk);
    solver_ready = '0; #1;
    chk("end_frame_done", 32'(frame_done), 1);
    chk("end_busy", 32'(busy), 1);
    chk("end_wr_en", 32'(wr_en), 0);
    @(negedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_frame_done", 32'(frame_done), 0);
    chk("idle_overflow_sticky", 32'(overflow), 1);

    solver_done = '0;
    step_start();
    #1;
    chk("restart_overflow_clear", 32'(overflow), 0);
    chk("restart_solver_reset", 32'(solver_reset), 1);

    // reset while RUN with two buffers valid
    @(negedge clk);
    solver_ready = 4'b0011; solver_out = 16'h0021; wr_ready = 1'b0;
    @(negedge clk);
    solver_ready = '0; #1;
    chk("midrst_pre_wr_en", 32'(wr_en), 1);
    chk("midrst_pre_continue", 32'(solver_continue), 32'h3);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_continue", 32'(solver_continue), 0);
    rst_n = 1'b1; wr_ready = 1'b1;
    @(negedge clk); #1;
    chk("midrst_after_frame_done", 32'(frame_done), 0);
    chk("midrst_after_wr_en", 32'(wr_en), 0);

    // full frame with a 3-cycle-latency solver model and periodic backpressure
    step_start();
    for (int i = 0; i < NS; i++) begin cnt[i] = 0; lat[i] = 2; end
    for (int i = 0; i < NR*NC; i++) seen[i] = 1'b0;
    writes = 0; fdone_cnt = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      wr_ready = ((cyc % 5) != 3);
      solver_ready = '0;
      for (int i = 0; i < NS; i++) solver_done[i] = (cnt[i] == 16);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (cnt[i] < 16 && !solver_continue[i]) begin
          if (lat[i] == 0) begin
            solver_ready[i] = 1'b1;
            solver_out[4*i +: 4] = pix(i + NS * (cnt[i] / NC), cnt[i] % NC);
            cnt[i]++;
            lat[i] = 2;
          end else begin
            lat[i]--;
          end
        end
      end
      #1;
      if (wr_en && wr_ready) begin
        a = int'(wr_addr);
        chk($sformatf("frame_data_a%0d", a), 32'(wr_data), 32'(pix(a / NC, a % NC)));
        chk($sformatf("frame_dup_a%0d", a), 32'(seen[a]), 0);
        seen[a] = 1'b1;
        writes++;
      end
      if (frame_done) begin
        fdone_cnt++;
        fin = 1'b1;
      end
    end
    nseen = 0;
    for (int i = 0; i < NR*NC; i++) nseen += int'(seen[i]);
    chk("frame_finished", 32'(fin), 1);
    chk("frame_writes", 32'(writes), NR*NC);
    chk("frame_addr_cover", 32'(nseen), NR*NC);
    chk("frame_overflow", 32'(overflow), 0);
    solver_ready = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      if (frame_done) fdone_cnt++;
      chk($sformatf("post_busy%0d", j), 32'(busy), 0);
    end
    chk("frame_done_once", 32'(fdone_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
